lsu_ctrl: RTL

- Load/store unit sitting directly upstream of the byte-addressed data memory.
- Accepts one load or store per handshake from the execute stage.
- Checks alignment and funct3 legality, then drives a word-aligned address, byte-lane mask and lane-shifted store data to the memory.
- Extracts and sign/zero-extends load data, and returns a registered response with a trap indication for the RV32I trap logic.

---
 rtl/lsu_ctrl.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/lsu_ctrl.sv
// Load/store unit between execute and byte-addressed data memory: legality and
// alignment checks, byte-lane steering, load extension and a registered response.
module lsu_ctrl #(
  parameter int ADDR_W          = 32,
  parameter int LOAD_MIS_CAUSE  = 4,
  parameter int STORE_MIS_CAUSE = 6,
  parameter int ILLEGAL_CAUSE   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic              flush,
  output logic              mrd,
  output logic              mwr,
  output logic [ADDR_W-1:0] adr,
  output logic [31:0]       d_in,
  output logic [3:0]        data_out_mask,
  input  logic [31:0]       d_out,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_exc,
  output logic [3:0]        resp_cause,
  output logic [ADDR_W-1:0] resp_tval
);

  typedef enum logic [1:0] {IDLE, MEM, RESP, FAULT} state_t;

  state_t     state;
  logic       we_q;
  logic [2:0] f3_q;
  logic [1:0] lane_q;
  logic       rvld_q;

  logic        accept, illegal, misal;
  logic [3:0]  cause_c, mask_c;
  logic [31:0] din_c, ld_ext;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // req_ready depends on rst so it reads 0 while reset is held
  assign req_ready  = rst & (state == IDLE) & ~flush;
  assign accept     = req_valid & req_ready;
  assign resp_valid = rvld_q & ~flush;

  always_comb begin
    illegal = req_we ? (req_funct3 >= 3'b011)
                     : (req_funct3 == 3'b011 || req_funct3 == 3'b110 || req_funct3 == 3'b111);
    misal   = (req_funct3[1:0] == 2'b01 && req_addr[0]) ||
              (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
    // illegal funct3 takes priority over misalignment
    if (illegal)     cause_c = 4'(ILLEGAL_CAUSE);
    else if (req_we) cause_c = 4'(STORE_MIS_CAUSE);
    else             cause_c = 4'(LOAD_MIS_CAUSE);

    case (req_funct3[1:0])
      2'b00: begin
        mask_c = 4'b0001 << req_addr[1:0];
        din_c  = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        mask_c = req_addr[1] ? 4'b1100 : 4'b0011;
        din_c  = {2{req_wdata[15:0]}};
      end
      default: begin
        mask_c = 4'b1111;
        din_c  = req_wdata;
      end
    endcase
  end

  always_comb begin
    byte_sel = d_out[{lane_q, 3'b000} +: 8];
    half_sel = lane_q[1] ? d_out[31:16] : d_out[15:0];
    case (f3_q)
      3'b000:  ld_ext = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  ld_ext = {{16{half_sel[15]}}, half_sel};
      3'b010:  ld_ext = d_out;
      3'b100:  ld_ext = {24'd0, byte_sel};
      3'b101:  ld_ext = {16'd0, half_sel};
      default: ld_ext = 32'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      we_q          <= 1'b0;
      f3_q          <= 3'd0;
      lane_q        <= 2'd0;
      rvld_q        <= 1'b0;
      mrd           <= 1'b0;
      mwr           <= 1'b0;
      adr           <= '0;
      d_in          <= 32'd0;
      data_out_mask <= 4'd0;
      resp_rdata    <= 32'd0;
      resp_exc      <= 1'b0;
      resp_cause    <= 4'd0;
      resp_tval     <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          we_q   <= req_we;
          f3_q   <= req_funct3;
          lane_q <= req_addr[1:0];
          if (illegal || misal) begin
            state      <= FAULT;
            rvld_q     <= 1'b1;
            resp_exc   <= 1'b1;
            resp_cause <= cause_c;
            resp_tval  <= req_addr;
            resp_rdata <= 32'd0;
          end else begin
            state         <= MEM;
            mrd           <= ~req_we;
            mwr           <= req_we;
            adr           <= {req_addr[ADDR_W-1:2], 2'b00};
            d_in          <= din_c;
            data_out_mask <= mask_c;
          end
        end
        MEM: begin
          // a flushed store has already committed; only its response is dropped
          state      <= RESP;
          mrd        <= 1'b0;
          mwr        <= 1'b0;
          rvld_q     <= ~flush;
          resp_exc   <= 1'b0;
          resp_rdata <= we_q ? 32'd0 : ld_ext;
        end
        default: begin
          state    <= IDLE;
          rvld_q   <= 1'b0;
          resp_exc <= 1'b0;
        end
      endcase
    end
  end

endmodule
